// File: rtl/tetron_move_ctrl.sv
// -----------------------------------------------------------------------------
// tetron_move_ctrl
//
// Purpose: sequences every candidate move of the falling tetromino (spawn,
// left, right, rotate-CW, down). The candidate rotation is presented to an
// external registered shaper. Each of the four returned block offsets is then
// bounds-checked, and in-bounds blocks are looked up on the board occupancy
// read port. The move is committed or rejected. This block owns the committed
// pivot position and rotation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   spawn_req           new piece at (SPAWN_V, SPAWN_H), rotation 0
//   move_req/move_cmd   move request (0=left 1=right 2=rotate CW 3=down),
//                       qualified by move_ready
//   move_ready          idle and not game over
//   shp_active          shaper enable, WAIT through RESOLVE
//   shp_rotation        candidate rotation to the shaper (bit2 always 0)
//   shp_offsets         {b4h,b4v,b3h,b3v,b2h,b2v,b1h,b1v}, 5-bit signed each
//   brd_rd_en/v/h       occupancy read strobe and cell
//   brd_rd_occ          occupancy, valid one cycle after brd_rd_en
//   pos_v/pos_h/rot     committed pivot and rotation
//   done/accepted/lock  result pulse, commit flag, down-rejected pulse
//   game_over           sticky, set by a rejected spawn
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request, candidate latched on acceptance
// WAIT    | shaper sees the candidate rotation, offsets not yet valid
// CHK1..4 | one block per cycle: bounds check and board read strobe
// RESOLVE | last occupancy response arrives
// REPORT  | done pulse, result and commit are visible
// -----------------------------------------------------------------------------
module tetron_move_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int SPAWN_H = 4,
  parameter int SPAWN_V = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spawn_req,
  input  logic        move_req,
  input  logic [1:0]  move_cmd,
  output logic        move_ready,
  output logic        shp_active,
  output logic [2:0]  shp_rotation,
  input  logic [39:0] shp_offsets,
  output logic        brd_rd_en,
  output logic [4:0]  brd_rd_v,
  output logic [4:0]  brd_rd_h,
  input  logic        brd_rd_occ,
  output logic [4:0]  pos_v,
  output logic [4:0]  pos_h,
  output logic [1:0]  rot,
  output logic        done,
  output logic        accepted,
  output logic        lock,
  output logic        game_over
);

  localparam logic [6:0] BW = 7'(BOARD_W);
  localparam logic [6:0] BH = 7'(BOARD_H);
  localparam logic [6:0] SV = 7'(SPAWN_V);
  localparam logic [6:0] SH = 7'(SPAWN_H);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CHK1    = 3'd2,
    S_CHK2    = 3'd3,
    S_CHK3    = 3'd4,
    S_CHK4    = 3'd5,
    S_RESOLVE = 3'd6,
    S_REPORT  = 3'd7
  } state_t;

  state_t     state;
  // Candidate pivot is kept in 7-bit two's complement so that h-1 at the
  // left wall becomes -1 and fails the bounds check instead of wrapping.
  logic [6:0] cand_v, cand_h;
  logic [1:0] cand_rot;
  logic       is_spawn, is_down;
  logic       coll;
  logic       pend;   // a read strobe was issued last cycle

  logic       take_spawn, take_move;
  logic [6:0] nxt_v, nxt_h;
  logic [1:0] nxt_rot;

  always_comb begin
    take_spawn = (state == S_IDLE) && !game_over && spawn_req;
    take_move  = (state == S_IDLE) && !game_over && move_ready && move_req && !spawn_req;
    nxt_v      = {2'b00, pos_v};
    nxt_h      = {2'b00, pos_h};
    nxt_rot    = rot;
    if (take_spawn) begin
      nxt_v   = SV;
      nxt_h   = SH;
      nxt_rot = 2'd0;
    end else begin
      case (move_cmd)
        2'd0:    nxt_h   = {2'b00, pos_h} - 7'd1;
        2'd1:    nxt_h   = {2'b00, pos_h} + 7'd1;
        2'd2:    nxt_rot = rot + 2'd1;
        default: nxt_v   = {2'b00, pos_v} + 7'd1;
      endcase
    end
  end

  logic [4:0] off_v, off_h;
  logic [6:0] cell_v, cell_h;
  logic       in_check, cell_ok, hit_last;

  always_comb begin
    off_v = '0;
    off_h = '0;
    case (state)
      S_CHK1: begin off_v = shp_offsets[4:0];   off_h = shp_offsets[9:5];   end
      S_CHK2: begin off_v = shp_offsets[14:10]; off_h = shp_offsets[19:15]; end
      S_CHK3: begin off_v = shp_offsets[24:20]; off_h = shp_offsets[29:25]; end
      S_CHK4: begin off_v = shp_offsets[34:30]; off_h = shp_offsets[39:35]; end
      default: ;
    endcase
  end

  assign cell_v   = cand_v + {{2{off_v[4]}}, off_v};
  assign cell_h   = cand_h + {{2{off_h[4]}}, off_h};
  assign in_check = (state == S_CHK1) || (state == S_CHK2) ||
                    (state == S_CHK3) || (state == S_CHK4);
  assign cell_ok  = !cell_v[6] && (cell_v < BH) && !cell_h[6] && (cell_h < BW);
  assign hit_last = pend && brd_rd_occ;

  assign brd_rd_en = in_check && cell_ok;
  assign brd_rd_v  = brd_rd_en ? cell_v[4:0] : 5'd0;
  assign brd_rd_h  = brd_rd_en ? cell_h[4:0] : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cand_v       <= '0;
      cand_h       <= '0;
      cand_rot     <= '0;
      is_spawn     <= 1'b0;
      is_down      <= 1'b0;
      coll         <= 1'b0;
      pend         <= 1'b0;
      move_ready   <= 1'b0;
      shp_active   <= 1'b0;
      shp_rotation <= '0;
      pos_v        <= '0;
      pos_h        <= '0;
      rot          <= '0;
      done         <= 1'b0;
      accepted     <= 1'b0;
      lock         <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      done     <= 1'b0;
      accepted <= 1'b0;
      lock     <= 1'b0;
      case (state)
        S_IDLE: begin
          move_ready <= !game_over;
          if (take_spawn || take_move) begin
            state        <= S_WAIT;
            cand_v       <= nxt_v;
            cand_h       <= nxt_h;
            cand_rot     <= nxt_rot;
            is_spawn     <= take_spawn;
            is_down      <= take_move && (move_cmd == 2'd3);
            coll         <= 1'b0;
            pend         <= 1'b0;
            move_ready   <= 1'b0;
            shp_active   <= 1'b1;
            shp_rotation <= {1'b0, nxt_rot};
          end
        end
        S_WAIT: state <= S_CHK1;
        S_CHK1, S_CHK2, S_CHK3, S_CHK4: begin
          coll  <= coll | hit_last | !cell_ok;
          pend  <= cell_ok;
          state <= (state == S_CHK4) ? S_RESOLVE : state_t'(state + 3'd1);
        end
        S_RESOLVE: begin
          state        <= S_REPORT;
          shp_active   <= 1'b0;
          shp_rotation <= '0;
          pend         <= 1'b0;
          done         <= 1'b1;
          accepted     <= !(coll | hit_last);
          lock         <= is_down & (coll | hit_last);
          if (!(coll | hit_last)) begin
            pos_v <= cand_v[4:0];
            pos_h <= cand_h[4:0];
            rot   <= cand_rot;
          end else if (is_spawn) begin
            game_over <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          move_ready <= !game_over;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tetron_move_ctrl.sv
module tb_tetron_move_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spawn_req, move_req;
  logic [1:0]  move_cmd;
  logic        move_ready, shp_active;
  logic [2:0]  shp_rotation;
  logic [39:0] shp_offsets;
  logic        brd_rd_en;
  logic [4:0]  brd_rd_v, brd_rd_h;
  logic        brd_rd_occ;
  logic [4:0]  pos_v, pos_h;
  logic [1:0]  rot;
  logic        done, accepted, lock, game_over;

  tetron_move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .move_req(move_req),
    .move_cmd(move_cmd), .move_ready(move_ready), .shp_active(shp_active),
    .shp_rotation(shp_rotation), .shp_offsets(shp_offsets), .brd_rd_en(brd_rd_en),
    .brd_rd_v(brd_rd_v), .brd_rd_h(brd_rd_h), .brd_rd_occ(brd_rd_occ),
    .pos_v(pos_v), .pos_h(pos_h), .rot(rot), .done(done), .accepted(accepted),
    .lock(lock), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit board [20][10];

  // L-shaped piece, rotation 0 offsets as (v,h): (0,0) (0,1) (0,2) (1,0).
  // Each clockwise quarter turn maps (v,h) -> (h,-v).
  function automatic void blk_off(input int r, input int k, output int dv, output int dh);
    int t;
    case (k)
      0: begin dv = 0; dh = 0; end
      1: begin dv = 0; dh = 1; end
      2: begin dv = 0; dh = 2; end
      default: begin dv = 1; dh = 0; end
    endcase
    for (int i = 0; i < r; i++) begin
      t = dv; dv = dh; dh = -t;
    end
  endfunction

  function automatic logic [39:0] pack_offs(input int r);
    logic [39:0] p;
    int dv, dh;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      blk_off(r, k, dv, dh);
      p[k*10 +: 5]     = 5'(dv);
      p[k*10 + 5 +: 5] = 5'(dh);
    end
    return p;
  endfunction

  // Registered shaper and board read port; junk whenever the data is not valid.
  always @(posedge clk) begin
    shp_offsets <= shp_active ? pack_offs(int'(shp_rotation[1:0])) : {$urandom, 8'($urandom)};
    if (brd_rd_en)
      brd_rd_occ <= (brd_rd_v < 5'd20 && brd_rd_h < 5'd10) ? board[brd_rd_v][brd_rd_h] : 1'b1;
    else
      brd_rd_occ <= 1'($urandom);
  end

  // ---------------- reference model ----------------
  int m_v, m_h, m_rot;
  bit m_go;
  bit e_srv, e_acc, e_lock;
  int e_crot;
  int e_sq[$];
  logic [11:0] e_done, e_act, e_rdy, e_acc_v, e_lock_v;

  task automatic model_step(input bit sp, input bit mr, input logic [1:0] cmd);
    int cv, ch, cr, dv, dh, v, h;
    bit coll;
    e_sq.delete();
    e_srv = !m_go && (sp || mr);
    e_acc = 0; e_lock = 0; e_crot = m_rot;
    if (e_srv) begin
      cv = m_v; ch = m_h; cr = m_rot;
      if (sp) begin cv = 1; ch = 4; cr = 0; end
      else case (cmd)
        2'd0: ch = m_h - 1;
        2'd1: ch = m_h + 1;
        2'd2: cr = (m_rot + 1) % 4;
        default: cv = m_v + 1;
      endcase
      coll = 0;
      for (int k = 0; k < 4; k++) begin
        blk_off(cr, k, dv, dh);
        v = cv + dv; h = ch + dh;
        if (v < 0 || v >= 20 || h < 0 || h >= 10) coll = 1;
        else begin
          e_sq.push_back((2 + k) * 10000 + v * 100 + h);
          if (board[v][h]) coll = 1;
        end
      end
      e_acc  = !coll;
      e_lock = !sp && cmd == 2'd3 && coll;
      e_crot = cr;
      if (!coll) begin m_v = cv; m_h = ch; m_rot = cr; end
      else if (sp) m_go = 1;
    end
    e_done   = e_srv ? 12'h040 : 12'h000;
    e_act    = e_srv ? 12'h03F : 12'h000;
    e_acc_v  = e_acc ? 12'h040 : 12'h000;
    e_lock_v = e_lock ? 12'h040 : 12'h000;
    e_rdy    = m_go ? 12'h000 : (e_srv ? 12'hF80 : 12'hFFF);
  endtask

  // ---------------- observation ----------------
  logic [11:0] o_done, o_acc, o_lock, o_act, o_rdy;
  logic [2:0]  o_srot [1:12];
  int          o_sq[$];
  logic [4:0]  o7_v, o7_h;
  logic [1:0]  o7_rot;
  logic        o7_go;

  task automatic run_req(input bit sp, input bit mr, input logic [1:0] cmd, input int busy_cyc);
    @(negedge clk);
    spawn_req = sp; move_req = mr; move_cmd = cmd;
    @(negedge clk);
    spawn_req = 0; move_req = 0;
    o_sq.delete();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (c == busy_cyc) begin move_req = 1; move_cmd = cmd; end
      else move_req = 0;
      o_done[c-1] = done;  o_acc[c-1] = accepted; o_lock[c-1] = lock;
      o_act[c-1]  = shp_active; o_rdy[c-1] = move_ready;
      o_srot[c]   = shp_rotation;
      if (brd_rd_en) o_sq.push_back(c * 10000 + int'(brd_rd_v) * 100 + int'(brd_rd_h));
      if (c == 7) begin o7_v = pos_v; o7_h = pos_h; o7_rot = rot; o7_go = game_over; end
    end
    move_req = 0;
  endtask

  function automatic bit sq_differs();
    if (o_sq.size() != e_sq.size()) return 1;
    foreach (o_sq[i]) if (o_sq[i] != e_sq[i]) return 1;
    return 0;
  endfunction

  function automatic bit srot_differs();
    for (int c = 1; c <= 6; c++) if (o_srot[c] !== {1'b0, 2'(e_crot)}) return 1;
    return 0;
  endfunction

  task automatic clear_board();
    for (int v = 0; v < 20; v++) for (int h = 0; h < 10; h++) board[v][h] = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({move_ready, shp_active, shp_rotation, brd_rd_en, brd_rd_v, brd_rd_h, pos_v, pos_h,
         rot, done, accepted, lock, game_over} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs, pos=(%0d,%0d) ready=%b", pos_v, pos_h, move_ready);
    end
    rst_n = 1;
    m_v = 0; m_h = 0; m_rot = 0; m_go = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (move_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", move_ready); end
  endtask

  task automatic test_spawn();
    clear_board();
    model_step(1, 0, 2'd0);
    run_req(1, 0, 2'd0, 0);
    n_cmp++;
    if (o_done !== 12'h040) begin n_bad++; $display("FAIL spawn_latency: done mask %h want 040", o_done); end
    n_cmp++;
    if (o_acc !== 12'h040) begin n_bad++; $display("FAIL spawn_accepted: mask %h want 040", o_acc); end
    n_cmp++;
    if ({o7_v, o7_h, o7_rot} !== {5'd1, 5'd4, 2'd0}) begin
      n_bad++; $display("FAIL spawn_pos: got (%0d,%0d,r%0d) want (1,4,r0)", o7_v, o7_h, o7_rot);
    end
    n_cmp++;
    if (o_sq.size() != 4 || sq_differs()) begin
      n_bad++; $display("FAIL spawn_strobes: got %p want %p", o_sq, e_sq);
    end
    n_cmp++;
    if (o_act !== 12'h03F || o_rdy !== 12'hF80) begin
      n_bad++; $display("FAIL spawn_handshake: active %h ready %h want 03F F80", o_act, o_rdy);
    end
  endtask

  task automatic test_left_edge();
    clear_board();
    for (int i = 0; i < 4; i++) begin
      model_step(0, 1, 2'd0);
      run_req(0, 1, 2'd0, 0);
      n_cmp++;
      if (o_acc !== 12'h040 || o7_h !== 5'(m_h)) begin
        n_bad++; $display("FAIL left_walk: acc %h h %0d want 040 h %0d", o_acc, o7_h, m_h);
      end
    end
    model_step(0, 1, 2'd0);
    run_req(0, 1, 2'd0, 0);
    n_cmp++;
    if (o_done !== 12'h040 || o_acc !== 12'h000 || o_lock !== 12'h000) begin
      n_bad++; $display("FAIL left_edge_reject: done %h acc %h lock %h want 040 000 000", o_done, o_acc, o_lock);
    end
    n_cmp++;
    if (o7_h !== 5'd0 || o7_v !== 5'd1) begin
      n_bad++; $display("FAIL left_edge_pos: got (%0d,%0d) want (1,0)", o7_v, o7_h);
    end
    n_cmp++;
    if (o_sq.size() != 2 || sq_differs()) begin
      n_bad++; $display("FAIL left_edge_strobes: got %p want %p", o_sq, e_sq);
    end
  endtask

  task automatic test_down_lock();
    clear_board();
    for (int i = 0; i < 17; i++) begin
      model_step(0, 1, 2'd3);
      run_req(0, 1, 2'd3, 0);
    end
    n_cmp++;
    if (o7_v !== 5'd18 || o_acc !== 12'h040) begin
      n_bad++; $display("FAIL down_walk: v %0d acc %h want 18 040", o7_v, o_acc);
    end
    model_step(0, 1, 2'd3);
    run_req(0, 1, 2'd3, 0);
    n_cmp++;
    if (o_done !== 12'h040 || o_acc !== 12'h000 || o_lock !== 12'h040) begin
      n_bad++; $display("FAIL down_lock: done %h acc %h lock %h want 040 000 040", o_done, o_acc, o_lock);
    end
    n_cmp++;
    if (o7_v !== 5'd18 || sq_differs() || o_sq.size() != 3) begin
      n_bad++; $display("FAIL down_lock_pos: v %0d strobes %p want 18 %p", o7_v, o_sq, e_sq);
    end
  endtask

  task automatic test_rotate_wrap();
    clear_board();
    model_step(1, 0, 2'd0); run_req(1, 0, 2'd0, 0);
    model_step(0, 1, 2'd3); run_req(0, 1, 2'd3, 0);
    model_step(0, 1, 2'd3); run_req(0, 1, 2'd3, 0);
    for (int i = 1; i <= 3; i++) begin
      model_step(0, 1, 2'd2); run_req(0, 1, 2'd2, 0);
      n_cmp++;
      if (o7_rot !== 2'(i) || o_acc !== 12'h040 || sq_differs()) begin
        n_bad++; $display("FAIL rotate_step%0d: rot %0d acc %h strobes %p want %0d 040 %p", i, o7_rot, o_acc, o_sq, i, e_sq);
      end
    end
    model_step(0, 1, 2'd2); run_req(0, 1, 2'd2, 0);
    n_cmp++;
    if (srot_differs()) begin
      n_bad++; $display("FAIL rotate_wrap_shaper: shp_rotation %0d..%0d want 0", o_srot[1], o_srot[6]);
    end
    n_cmp++;
    if (o7_rot !== 2'd0 || o_acc !== 12'h040) begin
      n_bad++; $display("FAIL rotate_wrap_commit: rot %0d acc %h want 0 040", o7_rot, o_acc);
    end
  endtask

  task automatic test_back_to_back();
    clear_board();
    model_step(0, 1, 2'd1); run_req(0, 1, 2'd1, 0);
    // spawn and move together: spawn wins, move is dropped
    model_step(1, 0, 2'd1);
    run_req(1, 1, 2'd1, 0);
    n_cmp++;
    if (o_done !== 12'h040 || {o7_v, o7_h, o7_rot} !== {5'd1, 5'd4, 2'd0} || sq_differs()) begin
      n_bad++; $display("FAIL spawn_priority: done %h pos (%0d,%0d,r%0d) want 040 (1,4,r0)", o_done, o7_v, o7_h, o7_rot);
    end
    // a request raised while busy is not queued
    model_step(0, 1, 2'd1);
    run_req(0, 1, 2'd1, 3);
    n_cmp++;
    if (o_done !== 12'h040 || o_act !== 12'h03F || pos_h !== 5'(m_h)) begin
      n_bad++; $display("FAIL busy_drop: done %h active %h h %0d want 040 03F %0d", o_done, o_act, pos_h, m_h);
    end
    n_cmp++;
    if (o_rdy !== 12'hF80) begin n_bad++; $display("FAIL busy_ready: got %h want F80", o_rdy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit sp;
      logic [1:0] cmd;
      sp  = ($urandom_range(0, 9) == 0);
      cmd = 2'($urandom_range(0, 3));
      for (int v = 0; v < 20; v++)
        for (int h = 0; h < 10; h++) board[v][h] = ($urandom_range(0, 99) < 12);
      if (sp) clear_board();
      model_step(sp, !sp, cmd);
      run_req(sp, !sp, cmd, 0);
      n_cmp++;
      if (o_done !== e_done) begin n_bad++; $display("FAIL rnd%0d_done: got %h want %h", i, o_done, e_done); end
      n_cmp++;
      if (o_acc !== e_acc_v) begin n_bad++; $display("FAIL rnd%0d_accepted: got %h want %h", i, o_acc, e_acc_v); end
      n_cmp++;
      if (o_lock !== e_lock_v) begin n_bad++; $display("FAIL rnd%0d_lock: got %h want %h", i, o_lock, e_lock_v); end
      n_cmp++;
      if (o_act !== e_act || o_rdy !== e_rdy) begin
        n_bad++; $display("FAIL rnd%0d_handshake: active %h ready %h want %h %h", i, o_act, o_rdy, e_act, e_rdy);
      end
      n_cmp++;
      if (sq_differs()) begin n_bad++; $display("FAIL rnd%0d_strobes: got %p want %p", i, o_sq, e_sq); end
      n_cmp++;
      if (srot_differs()) begin n_bad++; $display("FAIL rnd%0d_shp_rotation: got %0d want %0d", i, o_srot[1], e_crot); end
      n_cmp++;
      if ({o7_v, o7_h, o7_rot} !== {5'(m_v), 5'(m_h), 2'(m_rot)}) begin
        n_bad++; $display("FAIL rnd%0d_pos: got (%0d,%0d,r%0d) want (%0d,%0d,r%0d)", i, o7_v, o7_h, o7_rot, m_v, m_h, m_rot);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_board();
    @(negedge clk); spawn_req = 1;
    @(negedge clk); spawn_req = 0;           // WAIT
    @(negedge clk);                          // CHECK1
    @(negedge clk);                          // CHECK2
    n_cmp++;
    if (brd_rd_en !== 1'b1 || brd_rd_v !== 5'd1 || brd_rd_h !== 5'd5) begin
      n_bad++; $display("FAIL mid_check2_strobe: en %b cell (%0d,%0d) want 1 (1,5)", brd_rd_en, brd_rd_v, brd_rd_h);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({move_ready, shp_active, shp_rotation, brd_rd_en, brd_rd_v, brd_rd_h, pos_v, pos_h,
         rot, done, accepted, lock, game_over} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: active %b en %b pos (%0d,%0d)", shp_active, brd_rd_en, pos_v, pos_h);
    end
    o_done = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1;
      o_done[c] = done;
    end
    m_v = 0; m_h = 0; m_rot = 0; m_go = 0;
    n_cmp++;
    if (o_done !== 12'h000 || shp_active !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_no_done: done mask %h active %b want 000 0", o_done, shp_active);
    end
  endtask

  task automatic test_game_over();
    clear_board();
    board[1][5] = 1;
    model_step(1, 0, 2'd0);
    run_req(1, 0, 2'd0, 0);
    n_cmp++;
    if (o_done !== 12'h040 || o_acc !== 12'h000 || o7_go !== 1'b1) begin
      n_bad++; $display("FAIL spawn_reject: done %h acc %h game_over %b want 040 000 1", o_done, o_acc, o7_go);
    end
    n_cmp++;
    if ({o7_v, o7_h} !== {5'd0, 5'd0}) begin
      n_bad++; $display("FAIL spawn_reject_pos: got (%0d,%0d) want (0,0)", o7_v, o7_h);
    end
    model_step(0, 1, 2'd1);
    run_req(0, 1, 2'd1, 0);
    n_cmp++;
    if (o_done !== 12'h000 || o_act !== 12'h000 || o_rdy !== 12'h000 || o_sq.size() != 0) begin
      n_bad++; $display("FAIL game_over_move: done %h active %h ready %h want 000 000 000", o_done, o_act, o_rdy);
    end
    clear_board();
    model_step(1, 0, 2'd0);
    run_req(1, 0, 2'd0, 0);
    n_cmp++;
    if (o_done !== 12'h000 || game_over !== 1'b1) begin
      n_bad++; $display("FAIL game_over_spawn: done %h game_over %b want 000 1", o_done, game_over);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spawn_req = 0; move_req = 0; move_cmd = 2'd0; rst_n = 0;
    clear_board();
    test_reset();
    test_spawn();
    test_left_edge();
    test_down_lock();
    test_rotate_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_game_over();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
